// File: rtl/evo_circuit_scanner.sv
// evo_circuit_scanner: automatic stimulus sweep and response capture for the
// evolved-circuit test board. The block drives every input pattern to all
// circuits under test and waits for each one to settle. It then samples the
// output of one chosen channel and folds the results into two values: a CRC
// signature and a count of sampled ones.
module evo_circuit_scanner #(
  parameter int unsigned CHANNELS      = 32,
  parameter int unsigned SEL_WIDTH     = 5,
  parameter int unsigned IN_WIDTH      = 5,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned SIG_WIDTH     = 16,
  parameter logic [SIG_WIDTH-1:0] POLY = 16'h1021
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [SEL_WIDTH-1:0] chan_sel,
  input  logic [CHANNELS-1:0]  chan_outs,
  output logic [IN_WIDTH-1:0]  stim,
  output logic                 live_out,
  output logic                 busy,
  output logic                 done,
  output logic [SIG_WIDTH-1:0] signature,
  output logic [IN_WIDTH:0]    ones_count
);

  typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;

  // The last pattern of the sweep is all ones. The sweep stops there, so the
  // pattern counter never wraps.
  localparam logic [IN_WIDTH-1:0] LAST_PAT    = '1;
  localparam logic [7:0]          SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  state_t               state;
  logic [7:0]           settle_cnt;
  logic [IN_WIDTH-1:0]  pattern;
  logic [SEL_WIDTH-1:0] lsel;
  logic                 sample_bit;
  logic                 fb;

  // Channel mux. A select value past the last channel reads as 0 and never
  // indexes outside chan_outs.
  function automatic logic pick(input logic [CHANNELS-1:0] v,
                                input logic [SEL_WIDTH-1:0] s);
    pick = 1'b0;
    for (int i = 0; i < int'(CHANNELS); i++)
      if (32'(s) == 32'(i)) pick = v[i];
  endfunction

  // live_out is a zero-latency view of the channel named by the unlatched select.
  always_comb begin
    live_out = pick(chan_outs, chan_sel);
  end

  // The captured bit uses the select that was latched at start. That keeps a
  // running sweep on the same channel if chan_sel moves.
  always_comb begin
    sample_bit = pick(chan_outs, lsel);
    fb         = signature[SIG_WIDTH-1] ^ sample_bit;
  end

  // Sweep FSM. stim and all results are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      stim       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      signature  <= '0;
      ones_count <= '0;
      settle_cnt <= '0;
      pattern    <= '0;
      lsel       <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            lsel       <= chan_sel;
            signature  <= '0;
            ones_count <= '0;
            pattern    <= '0;
            settle_cnt <= '0;
            stim       <= '0;
            done       <= 1'b0;
            busy       <= 1'b1;
            state      <= APPLY;
          end
        end
        APPLY: begin
          // Hold stim for SETTLE_CYCLES clocks. The last of them moves to SAMPLE.
          if (settle_cnt == SETTLE_LAST) begin
            state <= SAMPLE;
          end else begin
            settle_cnt <= settle_cnt + 8'd1;
          end
        end
        SAMPLE: begin
          ones_count <= ones_count + {{IN_WIDTH{1'b0}}, sample_bit};
          signature  <= {signature[SIG_WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
          if (pattern == LAST_PAT) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            pattern    <= pattern + 1'b1;
            stim       <= pattern + 1'b1;
            settle_cnt <= '0;
            state      <= APPLY;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_evo_circuit_scanner.sv
// Directed bench for evo_circuit_scanner. The main instance uses the default
// 32 channels. A second instance with 29 channels covers the out-of-range select.
module tb_evo_circuit_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, start2;
  logic [4:0]  chan_sel, chan_sel2;
  logic [31:0] outs_static;
  logic        ident;
  logic [31:0] chan_outs;
  logic [28:0] chan_outs2;

  logic [4:0]  stim, stim2;
  logic        live_out, live_out2, busy, busy2, done, done2;
  logic [15:0] signature, signature2;
  logic [5:0]  ones_count, ones_count2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // In identity mode, channel 0 echoes stim[0].
  assign chan_outs = ident ? {outs_static[31:1], stim[0]} : outs_static;

  evo_circuit_scanner dut (
    .clk(clk), .rst(rst), .start(start), .chan_sel(chan_sel),
    .chan_outs(chan_outs), .stim(stim), .live_out(live_out), .busy(busy),
    .done(done), .signature(signature), .ones_count(ones_count)
  );

  evo_circuit_scanner #(.CHANNELS(29)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .chan_sel(chan_sel2),
    .chan_outs(chan_outs2), .stim(stim2), .live_out(live_out2), .busy(busy2),
    .done(done2), .signature(signature2), .ones_count(ones_count2)
  );

  // Reference CRC step.
  function automatic logic [15:0] crc_step(input logic [15:0] s, input logic b);
    crc_step = {s[14:0], 1'b0} ^ ((s[15] ^ b) ? 16'h1021 : 16'h0000);
  endfunction

  // Returns at the falling edge just after the edge that accepted start.
  task automatic pulse_start(input logic [4:0] sel);
    @(negedge clk);
    chan_sel = sel;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  // Follows a sweep. Counts stim values that differ from j/5 and reports the
  // cycle on which done first appears. The bound is 400 cycles; done_at stays -1
  // if done never rises.
  task automatic sweep_wait(output int stim_bad, output int done_at);
    stim_bad = 0;
    done_at  = -1;
    for (int j = 0; j < 400; j++) begin
      if (done) begin
        done_at = j;
        break;
      end
      if (stim !== 5'(j / 5)) stim_bad++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({busy, done, stim, signature, ones_count} !== '0) begin
      bad++;
      $display("FAIL reset_state: got busy=%b done=%b stim=%0d sig=%h ones=%0d want all 0",
               busy, done, stim, signature, ones_count);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({busy, done, stim} !== '0) begin
      bad++;
      $display("FAIL idle_hold: got busy=%b done=%b stim=%0d want 0", busy, done, stim);
    end
  endtask

  task automatic test_all_zero();
    int sb, da;
    ident = 1'b0; outs_static = 32'h0;
    pulse_start(5'd3);
    total++;
    if (busy !== 1'b1 || stim !== 5'd0) begin
      bad++;
      $display("FAIL zero_start: got busy=%b stim=%0d want busy=1 stim=0", busy, stim);
    end
    sweep_wait(sb, da);
    total++;
    if (da !== 160) begin
      bad++;
      $display("FAIL zero_latency: got %0d want 160", da);
    end
    total++;
    if (sb !== 0) begin
      bad++;
      $display("FAIL zero_stim_steps: got %0d wrong cycles want 0", sb);
    end
    total++;
    if (ones_count !== 6'd0 || signature !== 16'h0000 || busy !== 1'b0 || stim !== 5'd31) begin
      bad++;
      $display("FAIL zero_result: got ones=%0d sig=%h busy=%b stim=%0d want 0 0000 0 31",
               ones_count, signature, busy, stim);
    end
  endtask

  task automatic test_identity();
    int sb, da;
    logic [15:0] exp_sig;
    exp_sig = 16'h0;
    for (int k = 0; k < 32; k++) exp_sig = crc_step(exp_sig, k[0]);
    ident = 1'b1; outs_static = 32'h0;
    pulse_start(5'd0);
    sweep_wait(sb, da);
    total++;
    if (da !== 160 || sb !== 0) begin
      bad++;
      $display("FAIL ident_timing: got done_at=%0d stim_bad=%0d want 160 0", da, sb);
    end
    total++;
    if (ones_count !== 6'd16) begin
      bad++;
      $display("FAIL ident_ones: got %0d want 16", ones_count);
    end
    total++;
    if (signature !== exp_sig) begin
      bad++;
      $display("FAIL ident_sig: got %h want %h", signature, exp_sig);
    end
    ident = 1'b0;
  endtask

  task automatic test_reset_mid_sweep();
    ident = 1'b0; outs_static = 32'hFFFF_FFFF;
    pulse_start(5'd1);
    repeat (36) @(negedge clk);
    total++;
    if (stim !== 5'd7 || busy !== 1'b1) begin
      bad++;
      $display("FAIL mid_pre: got stim=%0d busy=%b want 7 1", stim, busy);
    end
    rst = 1'b1;
    #1;
    total++;
    if ({busy, done, stim, signature, ones_count} !== '0) begin
      bad++;
      $display("FAIL mid_reset: got busy=%b done=%b stim=%0d sig=%h ones=%0d want all 0",
               busy, done, stim, signature, ones_count);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, done, stim} !== '0) begin
      bad++;
      $display("FAIL mid_idle: got busy=%b done=%b stim=%0d want 0", busy, done, stim);
    end
  endtask

  task automatic test_start_ignored();
    int da;
    logic [15:0] exp_sig;
    exp_sig = 16'h0;
    for (int k = 0; k < 32; k++) exp_sig = crc_step(exp_sig, 1'b1);
    ident = 1'b0; outs_static = 32'h0000_0020;
    pulse_start(5'd5);
    da = -1;
    for (int j = 0; j < 400; j++) begin
      if (done) begin
        da = j;
        break;
      end
      if (j == 50) begin chan_sel = 5'd2; start = 1'b1; end
      if (j == 51) start = 1'b0;
      @(negedge clk);
    end
    total++;
    if (da !== 160) begin
      bad++;
      $display("FAIL busy_start_latency: got %0d want 160", da);
    end
    total++;
    if (ones_count !== 6'd32 || signature !== exp_sig) begin
      bad++;
      $display("FAIL busy_start_result: got ones=%0d sig=%h want 32 %h",
               ones_count, signature, exp_sig);
    end
    pulse_start(5'd5);
    total++;
    if (done !== 1'b0 || busy !== 1'b1 || stim !== 5'd0 || ones_count !== 6'd0) begin
      bad++;
      $display("FAIL restart: got done=%b busy=%b stim=%0d ones=%0d want 0 1 0 0",
               done, busy, stim, ones_count);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_select_latch();
    int da;
    ident = 1'b0; outs_static = 32'h0000_0200;
    pulse_start(5'd9);
    da = -1;
    for (int j = 0; j < 400; j++) begin
      if (done) begin
        da = j;
        break;
      end
      if (j == 20) begin
        total++;
        if (live_out !== 1'b1) begin
          bad++;
          $display("FAIL live_before: got %b want 1", live_out);
        end
        chan_sel = 5'd4;
        #1;
        total++;
        if (live_out !== 1'b0) begin
          bad++;
          $display("FAIL live_after: got %b want 0", live_out);
        end
      end
      @(negedge clk);
    end
    total++;
    if (da !== 160 || ones_count !== 6'd32) begin
      bad++;
      $display("FAIL latch_result: got done_at=%0d ones=%0d want 160 32", da, ones_count);
    end
  endtask

  task automatic test_out_of_range();
    int da;
    chan_outs2 = '1;
    chan_sel2  = 5'd28;
    #1;
    total++;
    if (live_out2 !== 1'b1) begin
      bad++;
      $display("FAIL oor_live_last: got %b want 1", live_out2);
    end
    chan_sel2 = 5'd30;
    #1;
    total++;
    if (live_out2 !== 1'b0) begin
      bad++;
      $display("FAIL oor_live: got %b want 0", live_out2);
    end
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    da = -1;
    for (int j = 0; j < 400; j++) begin
      if (done2) begin
        da = j;
        break;
      end
      @(negedge clk);
    end
    total++;
    if (da !== 160 || ones_count2 !== 6'd0 || signature2 !== 16'h0000) begin
      bad++;
      $display("FAIL oor_result: got done_at=%0d ones=%0d sig=%h want 160 0 0000",
               da, ones_count2, signature2);
    end
  endtask

  initial begin
    start = 1'b0; start2 = 1'b0;
    chan_sel = 5'd0; chan_sel2 = 5'd0;
    outs_static = 32'h0; ident = 1'b0; chan_outs2 = '0;
    test_reset();
    test_all_zero();
    test_identity();
    test_reset_mid_sweep();
    test_start_ignored();
    test_select_latch();
    test_out_of_range();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
